// File: rtl/adc_config_seq.sv
// Purpose: walks the config ROM window [FIRST_ADDR..LAST_ADDR] once per ADC chip and
//          strobes LOAD/SHEN/SCKEN to the shifter, with a gap between chips.
// Latency: INIT sampled at edge n gives the first LOAD after edge n; no backpressure (ABORT only).
// Ports:   i_clk, i_rst_n (sync, active low), i_init, i_abort ->
//          o_adr, o_load, o_shen, o_scken, o_cs (one-hot), o_busy, o_done, o_aborted
module adc_config_seq #(
  parameter int ADDR_W     = 5,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 16,
  parameter int SHIFT_LEN  = 47,
  parameter int NCHIP      = 1,
  parameter int GAP_CYC    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_adr,
  output logic              o_load,
  output logic              o_shen,
  output logic              o_scken,
  output logic [NCHIP-1:0]  o_cs,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted
);

  localparam int CHIP_W  = (NCHIP > 1) ? $clog2(NCHIP) : 1;
  localparam int CNT_MAX = (SHIFT_LEN > GAP_CYC) ? SHIFT_LEN : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_END, S_DONE
  } state_t;

  state_t              r_state, w_nstate;
  logic [ADDR_W-1:0]   r_addr, w_naddr;
  logic [CHIP_W-1:0]   r_chip, w_nchip;
  logic [CNT_W-1:0]    r_cnt, w_ncnt;
  logic                r_aborted, w_naborted;
  logic [ADDR_W-1:0]   r_adr;
  logic                r_load, r_shen, r_scken, r_busy, r_done;
  logic [NCHIP-1:0]    r_cs;
  logic [NCHIP-1:0]    w_onehot;

  always_comb begin
    w_nstate   = r_state;
    w_naddr    = r_addr;
    w_nchip    = r_chip;
    w_ncnt     = r_cnt;
    w_naborted = r_aborted;
    case (r_state)
      S_IDLE: begin
        if (i_init) begin
          w_nstate   = S_LOAD;
          w_nchip    = '0;
          w_naddr    = ADDR_W'(FIRST_ADDR);
          w_naborted = 1'b0;
        end
      end
      S_LOAD: begin
        w_nstate = S_SHIFT;
        w_ncnt   = '0;
      end
      S_SHIFT: begin
        w_ncnt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(SHIFT_LEN - 1)) begin
          // addr/chip never exceed their last values, so != is the same test as <
          if (r_addr != ADDR_W'(LAST_ADDR)) begin
            w_nstate = S_LOAD;
            w_naddr  = r_addr + ADDR_W'(1);
          end else if (r_chip != CHIP_W'(NCHIP - 1)) begin
            w_nstate = S_GAP;
            w_ncnt   = '0;
          end else begin
            w_nstate = S_END;
          end
        end
      end
      S_GAP: begin
        w_ncnt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
          w_nstate = S_LOAD;
          w_nchip  = r_chip + CHIP_W'(1);
          w_naddr  = ADDR_W'(FIRST_ADDR);
        end
      end
      S_END:  w_nstate = S_DONE;
      S_DONE: if (!i_init) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
    // ABORT beats every normal transition, including the last SHIFT cycle
    if (i_abort && (r_state == S_LOAD || r_state == S_SHIFT || r_state == S_GAP)) begin
      w_nstate   = S_END;
      w_naddr    = r_addr;
      w_nchip    = r_chip;
      w_naborted = 1'b1;
    end
  end

  assign w_onehot = NCHIP'(1) << w_nchip;

  // Outputs decode the next state so they line up with the state they describe
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= ADDR_W'(FIRST_ADDR);
      r_chip    <= '0;
      r_cnt     <= '0;
      r_aborted <= 1'b0;
      r_adr     <= ADDR_W'(FIRST_ADDR);
      r_load    <= 1'b0;
      r_shen    <= 1'b0;
      r_scken   <= 1'b0;
      r_cs      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_addr    <= w_naddr;
      r_chip    <= w_nchip;
      r_cnt     <= w_ncnt;
      r_aborted <= w_naborted;
      r_adr     <= w_naddr;
      r_load    <= (w_nstate == S_LOAD);
      r_shen    <= (w_nstate == S_SHIFT);
      // END keeps the serial clock running for one flush cycle
      r_scken   <= (w_nstate == S_LOAD) || (w_nstate == S_SHIFT) || (w_nstate == S_END);
      r_cs      <= (w_nstate == S_LOAD || w_nstate == S_SHIFT) ? w_onehot : '0;
      r_busy    <= (w_nstate != S_IDLE) && (w_nstate != S_DONE);
      r_done    <= (w_nstate == S_DONE);
    end
  end

  assign o_adr     = r_adr;
  assign o_load    = r_load;
  assign o_shen    = r_shen;
  assign o_scken   = r_scken;
  assign o_cs      = r_cs;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_aborted = r_aborted;

endmodule

// File: tb/tb_adc_config_seq.sv
module tb_adc_config_seq;

  typedef struct packed {
    logic [4:0] adr;
    logic       load;
    logic       shen;
    logic       scken;
    logic [1:0] cs;
    logic       busy;
    logic       done;
    logic       aborted;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init [2];
  logic       abort [2];
  logic [4:0] adr0, adr1;
  logic       load0, shen0, scken0, busy0, done0, ab0;
  logic       load1, shen1, scken1, busy1, done1, ab1;
  logic [0:0] cs0;
  logic [1:0] cs1;

  int total = 0;
  int bad   = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  always #5 clk = ~clk;

  adc_config_seq #(.ADDR_W(5), .FIRST_ADDR(0), .LAST_ADDR(2), .SHIFT_LEN(4),
                   .NCHIP(1), .GAP_CYC(2)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init[0]), .i_abort(abort[0]),
    .o_adr(adr0), .o_load(load0), .o_shen(shen0), .o_scken(scken0), .o_cs(cs0),
    .o_busy(busy0), .o_done(done0), .o_aborted(ab0));

  adc_config_seq #(.ADDR_W(5), .FIRST_ADDR(0), .LAST_ADDR(2), .SHIFT_LEN(4),
                   .NCHIP(2), .GAP_CYC(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init[1]), .i_abort(abort[1]),
    .o_adr(adr1), .o_load(load1), .o_shen(shen1), .o_scken(scken1), .o_cs(cs1),
    .o_busy(busy1), .o_done(done1), .o_aborted(ab1));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ADR is only meaningful while a word is loaded or shifting
  function automatic obs_t get(input int d, input logic keep_adr);
    obs_t o;
    if (d == 0) o = {adr0, load0, shen0, scken0, {1'b0, cs0}, busy0, done0, ab0};
    else        o = {adr1, load1, shen1, scken1, cs1, busy1, done1, ab1};
    if (!keep_adr) o.adr = '0;
    return o;
  endfunction

  function automatic obs_t mk(input int a, input logic l, s, k, input int cs,
                              input logic b, dn, ab);
    obs_t o;
    o = {5'(a), l, s, k, 2'(cs), b, dn, ab};
    return o;
  endfunction

  // Reference trace: one entry per cycle from the first LOAD to the first DONE cycle.
  // Abort during cycle k means cycle k+1 is END.
  task automatic build_exp(input int d, input int k);
    int nchip;
    logic ab;
    nchip = d + 1;
    ab = (k >= 0);
    exp_q.delete();
    for (int c = 0; c < nchip; c++) begin
      for (int a = 0; a <= 2; a++) begin
        exp_q.push_back(mk(a, 1, 0, 1, 1 << c, 1, 0, 0));
        repeat (4) exp_q.push_back(mk(a, 0, 1, 1, 1 << c, 1, 0, 0));
      end
      if (c < nchip - 1) repeat (3) exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    end
    if (ab) while (exp_q.size() > k + 1) void'(exp_q.pop_back());
    exp_q.push_back(mk(0, 0, 0, 1, 0, 1, 0, ab));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, ab));
  endtask

  // Drive one sequence on DUT d and record what it does (comparison is left to the caller)
  task automatic play(input int d, input int k, input int drop);
    obs_q.delete();
    init[d]  = 1'b1;
    abort[d] = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      obs_q.push_back(get(d, exp_q[i].load | exp_q[i].shen));
      abort[d] = (i == k);
      if (i == drop) init[d] = 1'b0;
    end
    abort[d] = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    init[0] = 1'b1; init[1] = 1'b1; abort[0] = 1'b0; abort[1] = 1'b0;
    repeat (3) begin
      step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (get(d, 1) !== obs_t'(0)) begin
          bad++; $display("FAIL reset_hold dut%0d: got %h want %h", d, get(d, 1), obs_t'(0));
        end
      end
    end
    rst_n = 1'b1;
    step();
    e = mk(0, 1, 0, 1, 1, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (get(d, 1) !== e) begin
        bad++; $display("FAIL reset_release_load dut%0d: got %h want %h", d, get(d, 1), e);
      end
    end
    step(); step();
    e = mk(0, 0, 1, 1, 1, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (get(d, 1) !== e) begin
        bad++; $display("FAIL reset_shift dut%0d: got %h want %h", d, get(d, 1), e);
      end
    end
    // reset in the middle of SHIFT: straight to IDLE, no END flush cycle
    rst_n = 1'b0; init[0] = 1'b0; init[1] = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (get(d, 1) !== obs_t'(0)) begin
        bad++; $display("FAIL reset_mid_shift dut%0d: got %h want %h", d, get(d, 1), obs_t'(0));
      end
    end
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (get(d, 1) !== obs_t'(0)) begin
        bad++; $display("FAIL reset_idle dut%0d: got %h want %h", d, get(d, 1), obs_t'(0));
      end
    end
  endtask

  // Full sequence on DUT d with INIT held; DONE must persist until INIT falls
  task automatic test_full(input int d, input string nm);
    obs_t e;
    build_exp(d, -1);
    play(d, -1, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL %s cycle %0d: got %h want %h", nm, i, obs_q[i], exp_q[i]);
      end
    end
    e = mk(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) begin
      step();
      total++;
      if (get(d, 0) !== e) begin
        bad++; $display("FAIL %s done_hold: got %h want %h", nm, get(d, 0), e);
      end
    end
    init[d] = 1'b0;
    step();
    total++;
    if (get(d, 0) !== obs_t'(0)) begin
      bad++; $display("FAIL %s back_to_idle: got %h want %h", nm, get(d, 0), obs_t'(0));
    end
  endtask

  // Abort in cycle k, check sticky ABORTED, ABORT ignored in DONE, cleared by fresh INIT
  task automatic test_abort(input int d, input int k, input string nm);
    obs_t e;
    build_exp(d, k);
    play(d, k, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL %s cycle %0d: got %h want %h", nm, i, obs_q[i], exp_q[i]);
      end
    end
    abort[d] = 1'b1;
    step();
    abort[d] = 1'b0;
    step();
    e = mk(0, 0, 0, 0, 0, 0, 1, 1);
    total++;
    if (get(d, 0) !== e) begin
      bad++; $display("FAIL %s abort_in_done: got %h want %h", nm, get(d, 0), e);
    end
    init[d] = 1'b0;
    step();
    e = mk(0, 0, 0, 0, 0, 0, 0, 1);
    total++;
    if (get(d, 0) !== e) begin
      bad++; $display("FAIL %s idle_sticky: got %h want %h", nm, get(d, 0), e);
    end
    build_exp(d, -1);
    play(d, -1, 0);
    total++;
    if (obs_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL %s reinit_clears: got %h want %h", nm, obs_q[0], exp_q[0]);
    end
    step();
  endtask

  // Random abort points and INIT drop points on either DUT
  task automatic test_random();
    int d, k, drop, n;
    obs_t e;
    for (int r = 0; r < 10; r++) begin
      d = $urandom_range(0, 1);
      build_exp(d, -1);
      n = exp_q.size() - 2;
      k = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, n - 1));
      drop = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, n));
      build_exp(d, k);
      play(d, k, drop);
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d d%0d k%0d cycle %0d: got %h want %h",
                          r, d, k, i, obs_q[i], exp_q[i]);
        end
      end
      if (drop < 0) begin
        step();
        init[d] = 1'b0;
      end
      step();
      e = mk(0, 0, 0, 0, 0, 0, 0, k >= 0);
      total++;
      if (get(d, 0) !== e) begin
        bad++; $display("FAIL rand%0d end_idle: got %h want %h", r, get(d, 0), e);
      end
    end
  endtask

  // INIT falls mid-SHIFT: sequence still completes, DONE lasts one cycle
  task automatic test_init_drop();
    build_exp(1, -1);
    play(1, -1, 12);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL init_drop cycle %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    step();
    total++;
    if (get(1, 0) !== obs_t'(0)) begin
      bad++; $display("FAIL init_drop idle: got %h want %h", get(1, 0), obs_t'(0));
    end
  endtask

  initial begin
    test_reset();
    test_full(0, "single_chip");
    test_full(1, "multi_chip");
    test_abort(0, 7, "abort_mid");
    test_abort(0, 14, "abort_last_shift");
    test_abort(1, 16, "abort_in_gap");
    test_init_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
